// File: rtl/note_pkg.sv
// -----------------------------------------------------------------------------
// note_pkg
//
// Shared definitions for the chart-playback sequencer (note_feeder) and its
// due-time comparator (note_due_cmp).
//
// Contents:
//   - chart record layout: {time[51:36], en[35:30], fret[29:0]}
//     field offsets, widths and a packed struct view of a record
//   - REC_W = 52, the record width as read from the chart ROM
//   - feeder_state_t, the sequencer state encoding
//   - rec_unpack(), which splits a raw ROM word into the struct view
//
// Configuration macro used by the design files: NOTE_FEEDER_STATS_EN.
// -----------------------------------------------------------------------------
package note_pkg;

    localparam int REC_W    = 52;

    localparam int TIME_MSB = 51;
    localparam int TIME_LSB = 36;
    localparam int EN_MSB   = 35;
    localparam int EN_LSB   = 30;
    localparam int FRET_MSB = 29;
    localparam int FRET_LSB = 0;

    localparam int TIME_W   = TIME_MSB - TIME_LSB + 1;  // 16
    localparam int EN_W     = EN_MSB - EN_LSB + 1;      // 6, one bit per string
    localparam int FRET_W   = FRET_MSB - FRET_LSB + 1;  // 30, 5 bits per string

    typedef struct packed {
        logic [TIME_W-1:0] at;    // scheduled song time of the chord
        logic [EN_W-1:0]   en;    // per-string enable; all-zero marks chart end
        logic [FRET_W-1:0] fret;  // per-string fret numbers
    } note_rec_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_WAIT,
        ST_HOLD,
        ST_EMIT,
        ST_DONE
    } feeder_state_t;

    // Split a raw ROM word into its fields using the published offsets, so
    // the struct view cannot drift from the documented record layout.
    function automatic note_rec_t rec_unpack(input logic [REC_W-1:0] raw);
        note_rec_t r;
        r.at   = raw[TIME_MSB:TIME_LSB];
        r.en   = raw[EN_MSB:EN_LSB];
        r.fret = raw[FRET_MSB:FRET_LSB];
        return r;
    endfunction

endpackage

// File: rtl/note_due_cmp.sv
// -----------------------------------------------------------------------------
// note_due_cmp
//
// Combinational due-time test for one chart record against the running song
// time. The difference is taken modulo 2^16 so that song_time wrapping past
// 16'hFFFF still yields the correct distance to the record.
//
// Parameters:
//   LOOKAHEAD  emission window in song_time units (must be < 32768)
//
// Ports:
//   rec_time   in  16  scheduled time of the held record
//   song_time  in  16  current song time
//   due        out 1   record is late or inside the look-ahead window
//   late       out 1   record time is already behind song_time
// -----------------------------------------------------------------------------
module note_due_cmp #(
    parameter logic [15:0] LOOKAHEAD = 16'd2000
) (
    input  logic [15:0] rec_time,
    input  logic [15:0] song_time,
    output logic        due,
    output logic        late
);

    logic [15:0] diff;

    always_comb begin
        // NOTE: every always_comb output gets an unconditional assignment
        // first, so no path through the block can leave a latch behind.
        diff = rec_time - song_time;
        // A negative distance (bit 15 set) means the chord is overdue; the
        // window limit keeps the positive range well below that bit.
        late = diff[15];
        due  = late || (diff <= LOOKAHEAD);
    end

endmodule

// File: rtl/note_feeder.sv
// -----------------------------------------------------------------------------
// note_feeder
//
// Chart-playback sequencer. Walks a synchronous chart ROM from address 0,
// holds each chord until it enters the look-ahead window relative to
// song_time, then issues a one-cycle per-string fret_en pulse together with
// the chord's fret numbers and chart time. An all-zero en field ends the
// chart; reaching the last ROM address also ends it after that record.
//
// Each record takes four cycles when it is already due:
//   FETCH (address stable) -> WAIT (ROM data valid, latched) -> HOLD
//   (due test) -> EMIT (fret_en pulse), so pulses are at least 4 cycles apart.
//
// Parameters:
//   ADDR_W      chart ROM address width
//   LOOKAHEAD   emission window in song_time units (must be < 32768)
//
// Ports:
//   clk            in  1       block clock (clk65 domain)
//   rst_n          in  1       synchronous active-low reset
//   start          in  1       pulse: (re)start playback from address 0
//   pause          in  1       level: holds a due record in HOLD
//   song_time      in  16      free-running song time, wraps mod 2^16
//   rom_addr       out ADDR_W  registered chart ROM address
//   rom_data       in  52      record {time, en, fret}, one cycle after addr
//   fret           out 30      fret numbers of the last emitted chord
//   fret_time      out 16      chart time of the last emitted chord
//   fret_en        out 6       one-cycle per-string load strobe
//   busy           out 1       playback in progress
//   done           out 1       chart finished
//   notes_emitted  out 16      (NOTE_FEEDER_STATS_EN) emitted chord count
//   late_count     out 16      (NOTE_FEEDER_STATS_EN) chords emitted late
//
// Configuration: define NOTE_FEEDER_STATS_EN to add the two saturating
// statistics counters and their output ports.
// -----------------------------------------------------------------------------
module note_feeder
    import note_pkg::*;
#(
    parameter int          ADDR_W    = 10,
    parameter logic [15:0] LOOKAHEAD = 16'd2000
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              pause,
    input  logic [15:0]       song_time,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [REC_W-1:0]  rom_data,
    output logic [FRET_W-1:0] fret,
    output logic [TIME_W-1:0] fret_time,
    output logic [EN_W-1:0]   fret_en,
    output logic              busy,
    output logic              done
`ifdef NOTE_FEEDER_STATS_EN
    ,
    output logic [15:0]       notes_emitted,
    output logic [15:0]       late_count
`endif
);

    feeder_state_t state;
    note_rec_t     rec;       // record currently being scheduled
    note_rec_t     rom_rec;   // field view of the word on rom_data
    logic          rec_due;
    logic          rec_late;

    assign rom_rec = rec_unpack(rom_data);

    note_due_cmp #(
        .LOOKAHEAD (LOOKAHEAD)
    ) u_due_cmp (
        .rec_time  (rec.at),
        .song_time (song_time),
        .due       (rec_due),
        .late      (rec_late)
    );

    // NOTE: all state and registered outputs are updated with non-blocking
    // assignments so every flop samples the pre-edge values of the others.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            rom_addr  <= '0;
            rec       <= '0;
            fret      <= '0;
            fret_time <= '0;
            fret_en   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else if (start) begin
            // Restart wins over everything, including a HOLD that was about
            // to move to EMIT this edge: that chord is simply re-fetched.
            state     <= ST_FETCH;
            rom_addr  <= '0;
            fret_en   <= '0;
            busy      <= 1'b1;
            done      <= 1'b0;
        end else begin
            // The strobe is only ever raised on the HOLD->EMIT edge below.
            fret_en <= '0;

            unique case (state)
                ST_IDLE: begin
                    state <= ST_IDLE;
                end

                ST_FETCH: begin
                    // rom_addr was registered last cycle; the ROM is reading.
                    state <= ST_WAIT;
                end

                ST_WAIT: begin
                    rec <= rom_rec;
                    if (rom_rec.en == '0) begin
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        state <= ST_HOLD;
                    end
                end

                ST_HOLD: begin
                    if (rec_due && !pause) begin
                        state     <= ST_EMIT;
                        fret_en   <= rec.en;
                        fret      <= rec.fret;
                        fret_time <= rec.at;
                    end
                end

                ST_EMIT: begin
                    if (&rom_addr) begin
                        // Last ROM location consumed without an end marker.
                        state <= ST_DONE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        rom_addr <= rom_addr + ADDR_W'(1);
                        state    <= ST_FETCH;
                    end
                end

                ST_DONE: begin
                    state <= ST_DONE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef NOTE_FEEDER_STATS_EN
    // Counters advance on the same edge that raises fret_en, so they count
    // exactly the pulses that reach the AV path. Both saturate at all-ones.
    always_ff @(posedge clk) begin
        if (!rst_n || start) begin
            notes_emitted <= '0;
            late_count    <= '0;
        end else if (state == ST_HOLD && rec_due && !pause) begin
            if (notes_emitted != 16'hFFFF) begin
                notes_emitted <= notes_emitted + 16'd1;
            end
            if (rec_late && late_count != 16'hFFFF) begin
                late_count <= late_count + 16'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_note_feeder.sv
// -----------------------------------------------------------------------------
// tb_note_feeder
//
// Self-checking bench for note_feeder. A chart-level model turns the ROM
// contents into the ordered list of chords that must appear on fret_en; a
// monitor pops that list on every pulse. Directed sequences check cycle
// timing, window gating, wrap/late handling, pause, restart and reset; a
// second instance with ADDR_W=2 checks the address-wrap end of chart.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_note_feeder;
    import note_pkg::*;

    localparam int          ADDR_W    = 10;
    localparam int          DEPTH     = 1 << ADDR_W;
    localparam logic [15:0] LOOKAHEAD = 16'd2000;

    typedef struct {
        logic [5:0]  en;
        logic [29:0] fret;
        logic [15:0] t;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n     = 1'b0;
    logic              start     = 1'b0;
    logic              start_s   = 1'b0;
    logic              pause     = 1'b0;
    logic [15:0]       song_time = 16'd0;

    logic [ADDR_W-1:0] rom_addr;
    logic [REC_W-1:0]  rom_data;
    logic [29:0]       fret;
    logic [15:0]       fret_time;
    logic [5:0]        fret_en;
    logic              busy, done;

    logic [1:0]        rom_addr_s;
    logic [REC_W-1:0]  rom_data_s;
    logic [29:0]       fret_s;
    logic [15:0]       fret_time_s;
    logic [5:0]        fret_en_s;
    logic              busy_s, done_s;

`ifdef NOTE_FEEDER_STATS_EN
    logic [15:0]       notes_emitted, late_count;
    logic [15:0]       notes_emitted_s, late_count_s;
`endif

    note_feeder #(.ADDR_W(ADDR_W), .LOOKAHEAD(LOOKAHEAD)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .pause     (pause),
        .song_time (song_time),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .fret      (fret),
        .fret_time (fret_time),
        .fret_en   (fret_en),
        .busy      (busy),
        .done      (done)
`ifdef NOTE_FEEDER_STATS_EN
        ,
        .notes_emitted (notes_emitted),
        .late_count    (late_count)
`endif
    );

    note_feeder #(.ADDR_W(2), .LOOKAHEAD(LOOKAHEAD)) dut_small (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start_s),
        .pause     (pause),
        .song_time (song_time),
        .rom_addr  (rom_addr_s),
        .rom_data  (rom_data_s),
        .fret      (fret_s),
        .fret_time (fret_time_s),
        .fret_en   (fret_en_s),
        .busy      (busy_s),
        .done      (done_s)
`ifdef NOTE_FEEDER_STATS_EN
        ,
        .notes_emitted (notes_emitted_s),
        .late_count    (late_count_s)
`endif
    );

    // Synchronous chart ROMs: data valid one cycle after the address.
    logic [REC_W-1:0] rom   [DEPTH];
    logic [REC_W-1:0] rom_s [4];

    always @(posedge clk) begin
        rom_data   <= rom[rom_addr];
        rom_data_s <= rom_s[rom_addr_s];
    end

    int   checks         = 0;
    int   failures       = 0;
    int   cyc            = 0;
    int   pulses         = 0;
    int   last_pulse_cyc = -100;
    int   pulse_cycs[$];
    int   s_pulse_cycs[$];
    exp_t exp_q[$];
    exp_t s_exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor for the main instance.
    always @(negedge clk) begin
        exp_t e;
        if (cyc > 0 && fret_en !== 6'd0) begin
            check("pulse_spacing", 64'(cyc - last_pulse_cyc > 1), 64'd1);
            pulses++;
            last_pulse_cyc = cyc;
            pulse_cycs.push_back(cyc);
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", 64'(fret_en), 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("fret_en", 64'(fret_en), 64'(e.en));
                check("fret", 64'(fret), 64'(e.fret));
                check("fret_time", 64'(fret_time), 64'(e.t));
            end
        end
    end

    // Scoreboard monitor for the ADDR_W=2 instance.
    always @(negedge clk) begin
        exp_t e;
        if (cyc > 0 && fret_en_s !== 6'd0) begin
            s_pulse_cycs.push_back(cyc);
            if (s_exp_q.size() == 0) begin
                check("small_unexpected_pulse", 64'(fret_en_s), 64'd0);
            end else begin
                e = s_exp_q.pop_front();
                check("small_fret_en", 64'(fret_en_s), 64'(e.en));
                check("small_fret", 64'(fret_s), 64'(e.fret));
            end
        end
    end

    // Inputs change just after the falling edge; monitors have already run.
    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    function automatic logic [REC_W-1:0] mk(input logic [15:0] t, input logic [5:0] en,
                                            input logic [29:0] f);
        return {t, en, f};
    endfunction

    task automatic clear_rom();
        foreach (rom[i]) rom[i] = '0;
    endtask

    // Reference model: chords play in address order until an all-zero en
    // or the last address; each is emitted exactly once with its chart data.
    task automatic start_main(output int s);
        exp_q.delete();
        pulse_cycs.delete();
        for (int a = 0; a < DEPTH; a++) begin
            if (rom[a][EN_MSB:EN_LSB] == 6'd0) break;
            exp_q.push_back('{en: rom[a][EN_MSB:EN_LSB], fret: rom[a][FRET_MSB:FRET_LSB],
                              t: rom[a][TIME_MSB:TIME_LSB]});
        end
        s     = cyc;
        start = 1'b1;
        step(1);
        start = 1'b0;
    endtask

    task automatic wait_pulse(input string name, input int exp_cyc);
        int p0 = pulses;
        int n  = 0;
        while (pulses == p0 && n < 200) begin
            step(1);
            n++;
        end
        check({name, "_pulse_cycle"}, 64'(last_pulse_cyc), 64'(exp_cyc));
    endtask

    task automatic wait_done(input string name, input int budget);
        int n = 0;
        while (done !== 1'b1 && n < budget) begin
            step(1);
            n++;
        end
        check({name, "_done"}, 64'(done), 64'd1);
        check({name, "_busy"}, 64'(busy), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int s, s2, c, p0, n, nlate, nw, prob, d;
        logic [15:0] base, tt;

        clear_rom();
        foreach (rom_s[i]) rom_s[i] = '0;

        // Reset, then idle with no start.
        rst_n = 1'b0;
        step(3);
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step(1);
            check("idle_outputs", {rom_addr, fret, fret_time, fret_en, busy, done}, 64'd0);
        end

        // Single chord: exact 4-cycle latency and DONE three cycles later.
        rom[0]    = mk(16'd5000, 6'b100001, 30'h0000_0003);
        song_time = 16'd3000;
        start_main(s);
        check("fetch_addr", 64'(rom_addr), 64'd0);
        check("start_busy", 64'(busy), 64'd1);
        wait_pulse("single", s + 4);
        check("single_fret_time_held", 64'(fret_time), 64'd5000);
        step(3);
        check("single_done_cycle", 64'(done), 64'd1);
        check("single_busy_low", 64'(busy), 64'd0);

        // Window gating: 2001 ahead is outside, 2000 ahead is inside.
        song_time = 16'd2999;
        start_main(s);
        p0 = pulses;
        step(20);
        check("gate_no_pulse", 64'(pulses), 64'(p0));
        check("gate_busy", 64'(busy), 64'd1);
        song_time = 16'd3000;
        c = cyc;
        wait_pulse("gate", c + 1);
        wait_done("gate", 20);

        // Record beyond the song_time wrap point, within the window.
        rom[0]    = mk(16'h0010, 6'b010110, 30'h1234567);
        song_time = 16'hFF00;
        start_main(s);
        wait_pulse("wrap", s + 4);
        wait_done("wrap", 20);

        // Late record: emitted at once with its original chart time.
        rom[0]    = mk(16'd100, 6'b000111, 30'h2AAAAAAA);
        song_time = 16'd900;
        start_main(s);
        wait_pulse("late", s + 4);
        wait_done("late", 20);
`ifdef NOTE_FEEDER_STATS_EN
        check("late_count", 64'(late_count), 64'd1);
        check("late_notes", 64'(notes_emitted), 64'd1);
`endif

        // Pause held in HOLD, then released.
        rom[0]    = mk(16'd5000, 6'b111111, 30'h0F0F0F0F);
        song_time = 16'd3000;
        pause     = 1'b1;
        start_main(s);
        p0 = pulses;
        step(52);
        check("pause_no_pulse", 64'(pulses), 64'(p0));
        pause = 1'b0;
        c = cyc;
        wait_pulse("pause_release", c + 1);
        wait_done("pause", 20);

        // Restart during WAIT of the second record.
        rom[0] = mk(16'd5000, 6'b000011, 30'h0000_1111);
        rom[1] = mk(16'd4000, 6'b110000, 30'h3000_0000);
        rom[2] = '0;
        start_main(s);
        wait_pulse("restart_pre", s + 4);
        step(2);
        check("restart_pre_addr", 64'(rom_addr), 64'd1);
        start_main(s2);
        check("restart_addr", 64'(rom_addr), 64'd0);
        p0 = pulses;
        step(2);
        check("restart_no_stale", 64'(pulses), 64'(p0));
        wait_pulse("restart_first", s2 + 4);
        wait_pulse("restart_second", s2 + 8);
        wait_done("restart", 20);
        check("restart_queue_empty", 64'(exp_q.size()), 64'd0);

        // Restart on the edge where a due HOLD would have emitted.
        start_main(s);
        step(2);
        start_main(s2);
        p0 = pulses;
        step(2);
        check("abandon_no_pulse", 64'(pulses), 64'(p0));
        wait_pulse("abandon_first", s2 + 4);
        wait_done("abandon", 40);

        // Reset mid-playback while a due record sits in HOLD.
        start_main(s);
        step(2);
        rst_n = 1'b0;
        exp_q.delete();
        p0 = pulses;
        step(1);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step(1);
            check("reset_mid_outputs", {rom_addr, fret, fret_time, fret_en, busy, done}, 64'd0);
        end
        check("reset_mid_no_pulse", 64'(pulses), 64'(p0));

        // Address wrap on the ADDR_W=2 instance: four pulses then DONE.
        s_exp_q.delete();
        s_pulse_cycs.delete();
        for (int i = 0; i < 4; i++) begin
            rom_s[i] = mk(16'd5000, 6'(i + 1), 30'($urandom));
            s_exp_q.push_back('{en: 6'(i + 1), fret: rom_s[i][FRET_MSB:FRET_LSB], t: 16'd5000});
        end
        song_time = 16'd3000;
        s = cyc;
        start_s = 1'b1;
        step(1);
        start_s = 1'b0;
        step(25);
        check("small_pulse_count", 64'(s_pulse_cycs.size()), 64'd4);
        for (int i = 0; i < s_pulse_cycs.size(); i++)
            check("small_pulse_cycle", 64'(s_pulse_cycs[i]), 64'(s + 4 + 4 * i));
        check("small_done", 64'(done_s), 64'd1);
        check("small_busy", 64'(busy_s), 64'd0);

        // Randomised charts; iteration 0 runs without pause to check spacing.
        for (int it = 0; it < 6; it++) begin
            clear_rom();
            n     = $urandom_range(1, 40);
            base  = 16'($urandom);
            nlate = 0;
            for (int i = 0; i < n; i++) begin
                if ($urandom_range(0, 1) == 1) begin
                    d = $urandom_range(32768, 65535);
                    nlate++;
                end else begin
                    d = $urandom_range(0, LOOKAHEAD);
                end
                tt     = 16'(base + 16'(d));
                rom[i] = mk(tt, 6'($urandom_range(1, 63)), 30'($urandom));
            end
            song_time = base;
            prob      = (it == 0) ? 0 : 30;
            start_main(s);
            nw = 0;
            while (done !== 1'b1 && nw < 2000) begin
                pause = ($urandom_range(0, 99) < prob);
                step(1);
                nw++;
            end
            pause = 1'b0;
            check("rand_done", 64'(done), 64'd1);
            check("rand_queue_empty", 64'(exp_q.size()), 64'd0);
            check("rand_pulse_count", 64'(pulse_cycs.size()), 64'(n));
            if (it == 0 && pulse_cycs.size() > 0) begin
                check("rand_first_cycle", 64'(pulse_cycs[0]), 64'(s + 4));
                for (int i = 1; i < pulse_cycs.size(); i++)
                    check("rand_back_to_back", 64'(pulse_cycs[i] - pulse_cycs[i-1]), 64'd4);
            end
`ifdef NOTE_FEEDER_STATS_EN
            check("rand_notes_emitted", 64'(notes_emitted), 64'(n));
            check("rand_late_count", 64'(late_count), 64'(nlate));
`endif
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/note_feeder.md
# note_feeder

Chart-playback sequencer that produces the per-string note events consumed by the AV display path. It walks a synchronous chart ROM in order and compares each chord's scheduled time against the running `song_time`. When a chord enters the look-ahead window it issues a one-cycle `fret_en` pulse with `fret` and `fret_time`. It sits between the chart memory and the AV block, in the `clk65` pixel-clock domain.

## Interface
Parameters:
- `ADDR_W`, 10: chart ROM address width; chart holds at most 2^ADDR_W records.
- `LOOKAHEAD`, 16'd2000: emission window in `song_time` units. Must be < 32768.

Ports:
- `clk` in 1: single clock for the block (tie to `clk65`).
- `rst_n` in 1: synchronous, active-low reset.
- `start` in 1: one-cycle pulse that (re)starts playback from address 0.
- `pause` in 1: level; when high, holds emission.
- `song_time` in 16: current song time, free-running, wraps mod 2^16.
- `rom_addr` out ADDR_W: registered chart ROM address.
- `rom_data` in 52: record `{time[51:36], en[35:30], fret[29:0]}`, valid one cycle after `rom_addr`.
- `fret` out 30: 5 bits per string, string 6 in [29:25] down to string 1 in [4:0].
- `fret_time` out 16: scheduled time of the emitted chord.
- `fret_en` out 6: per-string load strobe; bit 5 = string 6.
- `busy` out 1: high from a `start` until DONE.
- `done` out 1: high in DONE.

## Operation
- States: IDLE, FETCH, WAIT, HOLD, EMIT, DONE.
- IDLE: outputs quiet. `start` goes to FETCH with `rom_addr`=0.
- FETCH: `rom_addr` is stable and the ROM is being read. Next state is WAIT.
- WAIT: at the end of this cycle, latch `rom_data` into the record register. If `en`==0 (end marker), go to DONE; otherwise go to HOLD.
- HOLD: compute `diff = rec_time - song_time` (16-bit, mod 2^16).
  - The record is due if `diff[15]`==1 (late) or `diff <= LOOKAHEAD`.
  - Go to EMIT if due and `pause`==0; otherwise stay in HOLD.
- EMIT: `fret_en = rec_en` for exactly this cycle. `fret` and `fret_time` are loaded from the record on entry to EMIT and held until the next EMIT.
  - If `rom_addr` is all-ones, go to DONE.
  - Otherwise increment `rom_addr` and go to FETCH.
- DONE: `done`=1, `busy`=0. Stays in DONE until `start`.
- Late records are emitted unchanged; `fret_time` keeps the chart time.
- `start` in any state overrides everything: `rom_addr`=0 and next state is FETCH. A pending EMIT is abandoned and no `fret_en` pulse is issued that cycle.
- `pause` only gates the HOLD→EMIT transition. An EMIT already entered completes.
- `song_time` jumping backward is not detected; the controller restarts playback with `start`.

## Timing
- Reset values (all outputs): `rom_addr`=0, `fret`=0, `fret_time`=0, `fret_en`=0, `busy`=0, `done`=0; state IDLE.
- Reset asserted mid-playback takes effect at the next edge; no pulse is emitted afterwards.
- Per-record sequence, with `start` sampled at cycle 0:
  - Cycle 1: FETCH, `rom_addr`=0.
  - Cycle 2: WAIT.
  - Cycle 3: HOLD.
  - Earliest `fret_en` pulse is at cycle 4.
- Back-to-back due records: one pulse every 4 cycles. `fret_en` is never high on two consecutive cycles.
- All outputs are registered; there is no combinational path from any input to any output.

## Configuration
- `NOTE_FEEDER_STATS_EN` defined: adds output `notes_emitted[15:0]` and output `late_count[15:0]`.
  - `notes_emitted` increments on each EMIT.
  - `late_count` increments on each EMIT whose `diff[15]` was 1.
  - Both counters saturate at 16'hFFFF and clear on reset and on `start`.
- Macro undefined: the two ports and the counters do not exist. All other behaviour is identical.

## Structure
- Shared package `note_pkg` holds:
  - record field offsets and widths (TIME_MSB/LSB, EN_MSB/LSB, FRET_MSB/LSB);
  - `REC_W`=52;
  - the state enum `feeder_state_t`.
- One sub-module, `note_due_cmp`: combinational. Inputs are `rec_time`, `song_time` and `LOOKAHEAD`; outputs are `due` and `late`.

## Test plan
- Reset/idle: hold `rst_n`=0 for 3 cycles, then release with no `start`. All outputs stay 0 and `rom_addr`=0 for 20 cycles.
- Single chord:
  - Stimulus: ROM[0] = {time 5000, en 6'b100001, fret 30'h0000_0003}, ROM[1] en=0; `song_time` held at 3000; pulse `start`.
  - Response: `fret_en`=6'b100001 for one cycle at cycle 4, `fret_time`=5000, then `done`=1 after ROM[1] is read.
- Window gating: `song_time`=2999, record time 5000. No pulse. Step `song_time` to 3000; pulse appears 1 cycle later.
- Wrap and late:
  - Record time 16'h0010 with `song_time`=16'hFF00 → diff=0x0110, due (within window).
  - Record time 100 with `song_time`=900 → late, emitted immediately; with the stats macro, `late_count`=1.
- Pause and restart:
  - Assert `pause` in HOLD for 50 cycles → no pulse. Deassert → pulse on the next cycle.
  - Pulse `start` during WAIT → `rom_addr` returns to 0 and no stale pulse is issued.
- Address wrap: `ADDR_W`=2 with 4 due records and no end marker. Exactly 4 pulses, 4 cycles apart, then DONE.
